decode_fetch_queue: RTL and testbench
=====================================

Name: decode_fetch_queue

Overview:
- Parametrised instruction holding queue between the program cache and the decode stage; replaces the single-entry hazard-alternate register with a DEPTH-entry circular buffer.
- Absorbs fetches that arrive while decode is stalled by a hazard.
- Injects NOPs on cache miss or empty queue.
- Supports flush on taken branch and reports back-pressure to fetch.

Parameters:
- IW, 16, instruction width in bits.
- DEPTH, 4, queue entries; integer >= 2; need not be a power of two.
- NOP_WORD, {IW{1'b0}}, instruction word injected when no valid instruction is available.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- I  in  IW  fetched instruction word from the program cache.
- I_valid  in  1  I carries a real instruction this cycle (low = cache miss).
- hazard  in  1  decode stall; I_out must hold while high.
- flush  in  1  taken branch/XEC/CALL/RET; discards queued and in-flight words.
- I_out  out  IW  registered instruction presented to decode.
- fetch_stall  out  1  combinational; high when count == DEPTH; fetch must not advance.
- count  out  $clog2(DEPTH+1)  registered number of occupied entries.
- overflow  out  1  sticky error; a push was dropped because the queue was full.

Behaviour:
- Reset (RST high at an edge):
  - I_out = NOP_WORD, count = 0, overflow = 0.
  - Read and write pointers = 0; storage contents are don't-care.
  - Reset has priority over every other input, including mid-stall or mid-flush.
- Definitions:
  - push_req = I_valid & ~flush.
  - pop = ~hazard.
  - empty = (count == 0); full = (count == DEPTH).
- Priority per edge: RST, then flush, then normal operation.
- Flush:
  - count <= 0; pointers <= 0; I_out <= NOP_WORD, regardless of hazard.
  - The word on I in the same cycle is discarded.
  - overflow is unaffected.
- Normal operation, pop high:
  - If empty and push_req: bypass, I_out <= I. Queue unchanged. Latency is 1 cycle, same as the legacy path.
  - If empty and not push_req: I_out <= NOP_WORD.
  - If not empty: I_out <= head entry and the read pointer advances. If push_req, I is written at the write pointer in the same cycle and count is unchanged; otherwise count decrements.
- Normal operation, pop low:
  - I_out holds its value.
  - If push_req and not full: write I at the write pointer, write pointer advances, count increments.
  - If push_req and full: word dropped, overflow <= 1.
- Full with simultaneous push and pop: legal. The pop frees the head, the push writes, and count stays at DEPTH.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0. Explicit compare, no reliance on power-of-two modulo.
- Ordering: strict FIFO; words reach I_out in fetch order.
- Invariants:
  - count never exceeds DEPTH.
  - count never underflows.
  - fetch_stall == (count == DEPTH) in every cycle.

Decomposition:
- Shared package riptide_pkg holds:
  - IW_DEFAULT = 16.
  - NOP_WORD_DEFAULT = 16'h0000.
  - Opcode constants for the decode stage.
- One natural sub-module: decode_fifo_mem. It is a DEPTH x IW register array with a write port and an asynchronous read of the head entry.
- Pointers, count, bypass and NOP muxing stay in the top module.

Test Plan:
- Reset release; I_valid=1, I=16'h2105, hazard=0 -> I_out=16'h2105 one cycle later, count=0.
- hazard high for 3 cycles while I=16'hA001, 16'hA002, 16'hA003 valid -> I_out holds; count goes 1,2,3. hazard low -> I_out shows A001, A002, A003 on successive cycles, then NOP_WORD if I_valid=0.
- DEPTH=4, hazard held, 5 valid pushes -> count=4, fetch_stall=1, overflow=1 after the 5th; the first four words drain in order.
- Queue holding 2 words, flush=1 with I_valid=1, I=16'hE0FF -> next cycle I_out=16'h0000, count=0; E0FF never appears.
- Full queue (count=4), hazard=0, I_valid=1 for 8 cycles -> count stays 4, no overflow, output order matches input order across pointer wrap.
- Cache miss (I_valid=0) with empty queue and hazard=0 -> I_out=16'h0000. RST asserted mid-stall with count=3 -> count=0 and overflow=0 on the next edge.

Source files
------------

// File: rtl/riptide_pkg.sv
// rtl/riptide_pkg.sv - shared widths, NOP word and decode opcode constants
package riptide_pkg;

  localparam int IW_DEFAULT = 16;
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  // Major opcode lives in the top nibble of the instruction word.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'hA;
  localparam logic [3:0] OP_XEC  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  function automatic logic [3:0] major_op(input logic [15:0] word);
    return word[15:12];
  endfunction

  function automatic logic is_flow_change(input logic [15:0] word);
    logic [3:0] op;
    op = major_op(word);
    return (op == OP_XEC) || (op == OP_CALL) || (op == OP_JMP) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/decode_fifo_mem.sv
// rtl/decode_fifo_mem.sv - DEPTH x IW register array, one write port, async head read
module decode_fifo_mem
  import riptide_pkg::*;
#(
  parameter int IW    = IW_DEFAULT,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  // Contents are deliberately not reset; the pointers guard every read.
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/decode_fetch_queue.sv
// rtl/decode_fetch_queue.sv - fetch-to-decode holding queue with bypass, NOP fill and flush
module decode_fetch_queue
  import riptide_pkg::*;
#(
  parameter int            IW       = IW_DEFAULT,
  parameter int            DEPTH    = 4,
  parameter logic [IW-1:0] NOP_WORD = {IW{1'b0}}
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [IW-1:0]              I,
  input  logic                       I_valid,
  input  logic                       hazard,
  input  logic                       flush,
  output logic [IW-1:0]              I_out,
  output logic                       fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;
  logic [IW-1:0] head;
  logic          push_req;
  logic          pop;
  logic          empty;
  logic          full;
  logic          wr_en;

  assign push_req    = I_valid & ~flush;
  assign pop         = ~hazard;
  assign empty       = (count == '0);
  assign full        = (count == FULL_COUNT);
  assign fetch_stall = full;

  // Explicit wrap so non-power-of-two depths stay correct.
  assign rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
  assign wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);

  // Empty-queue pushes with pop high take the bypass and never touch storage.
  assign wr_en = ~RST & push_req & ((pop & ~empty) | (~pop & ~full));

  decode_fifo_mem #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (I),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      I_out    <= NOP_WORD;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      I_out  <= NOP_WORD;
    end else if (pop) begin
      if (empty) begin
        I_out <= push_req ? I : NOP_WORD;
      end else begin
        I_out  <= head;
        rd_ptr <= rd_ptr_next;
        if (push_req) begin
          wr_ptr <= wr_ptr_next;
        end else begin
          count <= count - CW'(1);
        end
      end
    end else if (push_req) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr_next;
        count  <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// tb/tb_decode_fetch_queue.sv - randomized and directed checks against a queue-based model
module tb_decode_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] I = '0;
  logic        I_valid = 1'b0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] I_out;
  logic        fetch_stall;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  logic [15:0] q[$];
  logic [15:0] exp_out = NOP;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  decode_fetch_queue #(.IW(16), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .RST         (RST),
    .I           (I),
    .I_valid     (I_valid),
    .hazard      (hazard),
    .flush       (flush),
    .I_out       (I_out),
    .fetch_stall (fetch_stall),
    .count       (count),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, check every output after the edge.
  task automatic step(input bit r, input bit v, input logic [15:0] w, input bit h, input bit f);
    RST = r; I_valid = v; I = w; hazard = h; flush = f;
    #1;
    if (!r && total > 0) chk("stall_pre", fetch_stall, (q.size() == DEPTH));
    if (r) begin
      q.delete();
      exp_out = NOP;
      exp_ovf = 1'b0;
    end else if (f) begin
      q.delete();
      exp_out = NOP;
    end else if (!h) begin
      if (q.size() == 0) begin
        exp_out = v ? w : NOP;
      end else begin
        exp_out = q.pop_front();
        if (v) q.push_back(w);
      end
    end else if (v) begin
      if (q.size() < DEPTH) q.push_back(w);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("i_out", I_out, exp_out);
    chk("count", count, q.size());
    chk("overflow", overflow, exp_ovf);
    chk("stall", fetch_stall, (q.size() == DEPTH));
  endtask

  initial begin
    step(1, 0, '0, 0, 0);
    step(1, 1, 16'h1234, 1, 1);
    chk("reset_out", I_out, NOP);
    chk("reset_count", count, 0);

    step(0, 1, 16'h2105, 0, 0);
    chk("bypass", I_out, 16'h2105);

    step(0, 1, 16'hA001, 1, 0);
    step(0, 1, 16'hA002, 1, 0);
    step(0, 1, 16'hA003, 1, 0);
    chk("hold_out", I_out, 16'h2105);
    chk("hold_count", count, 3);
    step(0, 0, '0, 0, 0);
    chk("drain1", I_out, 16'hA001);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("drain3", I_out, 16'hA003);
    step(0, 0, '0, 0, 0);
    chk("miss_nop", I_out, NOP);

    for (int i = 1; i <= 5; i++) step(0, 1, 16'hB000 + 16'(i), 1, 0);
    chk("full_count", count, 4);
    chk("full_ovf", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, '0, 0, 0);
      chk("full_drain", I_out, 16'hB000 + 16'(i));
    end

    step(1, 0, '0, 0, 0);
    step(0, 1, 16'hD001, 1, 0);
    step(0, 1, 16'hD002, 1, 0);
    step(0, 1, 16'hE0FF, 1, 1);
    chk("flush_out", I_out, NOP);
    chk("flush_count", count, 0);
    step(0, 0, '0, 0, 0);
    chk("flush_gone", I_out, NOP);

    for (int i = 0; i < 4; i++) step(0, 1, 16'hC000 + 16'(i), 1, 0);
    for (int i = 4; i < 12; i++) begin
      step(0, 1, 16'hC000 + 16'(i), 0, 0);
      chk("wrap_order", I_out, 16'hC000 + 16'(i - 4));
      chk("wrap_count", count, 4);
    end
    chk("wrap_ovf", overflow, 0);

    for (int i = 0; i < 3; i++) step(0, 1, 16'hF100 + 16'(i), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'hF200 + 16'(i), 1, 0);
    step(1, 1, 16'hF300, 1, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ovf", overflow, 0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
